// File: rtl/sd_block_arbiter_if.sv
// Bundle of requester-side and SD-controller-side signals for sd_block_arbiter.
// master = arbiter view, slave = requesters + controller view.
`timescale 1ns/1ps
interface sd_block_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_op_code;
  logic [NUM_REQ-1:0][31:0] req_block_address;
  logic [NUM_REQ-1:0][7:0]  req_outgoing_byte;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       req_byte_strobe;
  logic [NUM_REQ-1:0]       req_done;
  logic [NUM_REQ-1:0]       req_timeout;
  logic [7:0]               incoming_byte;

  logic                     sd_op_code;
  logic                     sd_execute;
  logic [31:0]              sd_block_address;
  logic [7:0]               sd_outgoing_byte;
  logic [7:0]               sd_incoming_byte;
  logic                     sd_finished_byte;
  logic                     sd_finished_block;
  logic                     sd_busy;

  modport master (
    input  req, req_op_code, req_block_address, req_outgoing_byte,
    input  sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy,
    output gnt, req_byte_strobe, req_done, req_timeout, incoming_byte,
    output sd_op_code, sd_execute, sd_block_address, sd_outgoing_byte
  );

  modport slave (
    output req, req_op_code, req_block_address, req_outgoing_byte,
    output sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy,
    input  gnt, req_byte_strobe, req_done, req_timeout, incoming_byte,
    input  sd_op_code, sd_execute, sd_block_address, sd_outgoing_byte
  );
endinterface

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one SD card controller between NUM_REQ block requesters.
// One grant = one sector transfer; a watchdog aborts grants when the card stalls.
`timescale 1ns/1ps
module sd_block_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_block_arbiter_if.master   bus
);

    localparam int                IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [23:0]       TMO      = 24'(TIMEOUT_CYCLES);
    localparam logic [IDXW-1:0]   LAST_RST = IDXW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_XFER, S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDXW-1:0]      gidx_q, gidx_d;
    logic [IDXW-1:0]      last_q, last_d;
    logic                 op_q, op_d;
    logic [31:0]          addr_q, addr_d;
    logic [23:0]          cnt_q, cnt_d;

    logic                 done_p, tmo_p, in_xfer;
    logic [23:0]          cnt_inc;
    logic                 wd_hit;

    // Round-robin pick: lowest index above last_q wins, otherwise lowest index overall.
    logic                 hi_vld, any_vld, win_vld;
    logic [IDXW-1:0]      hi_idx, any_idx, win_idx;

    always_comb begin
        hi_vld  = 1'b0;
        hi_idx  = '0;
        any_vld = 1'b0;
        any_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i[IDXW-1:0]]) begin
                any_vld = 1'b1;
                any_idx = i[IDXW-1:0];
                if (i > int'(last_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = i[IDXW-1:0];
                end
            end
        end
        win_vld = any_vld;
        win_idx = hi_vld ? hi_idx : any_idx;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_p  = 1'b0;
        tmo_p   = 1'b0;
        cnt_inc = cnt_q + 24'd1;
        wd_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // sd_busy also covers card init and a transfer orphaned by our own reset.
                if (!bus.sd_busy && win_vld) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    op_d    = bus.req_op_code[win_idx];
                    addr_d  = bus.req_block_address[win_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.sd_busy) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (wd_hit) begin
                    tmo_p   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_XFER: begin
                if (bus.sd_finished_block || !bus.sd_busy) begin
                    done_p  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (bus.sd_finished_byte) begin
                    cnt_d = '0;
                end else if (wd_hit) begin
                    tmo_p   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                cnt_d = '0;
                if (!bus.sd_busy) begin
                    gnt_d   = '0;
                    last_d  = gidx_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            op_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte-level paths stay combinational so strobes and write data see no extra latency.
    assign in_xfer              = (state_q == S_XFER);
    assign bus.gnt              = gnt_q;
    assign bus.sd_execute       = (state_q == S_ISSUE);
    assign bus.sd_op_code       = op_q;
    assign bus.sd_block_address = addr_q;
    assign bus.incoming_byte    = in_xfer ? bus.sd_incoming_byte : 8'h00;
    assign bus.sd_outgoing_byte = in_xfer ? bus.req_outgoing_byte[gidx_q] : 8'h00;
    assign bus.req_byte_strobe  = (in_xfer && bus.sd_finished_byte) ? gnt_q : '0;
    assign bus.req_done         = done_p ? gnt_q : '0;
    assign bus.req_timeout      = tmo_p  ? gnt_q : '0;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Bench for sd_block_arbiter: task-driven SD controller model with a scoreboard of
// expected strobe/done/timeout events, consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_sd_block_arbiter;
  localparam int NR  = 2;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_block_arbiter_if #(.NUM_REQ(NR)) bus();
  sd_block_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // kind: 0 byte strobe, 1 done, 2 timeout
  typedef struct { int kind; int idx; logic [7:0] data; } ev_t;
  ev_t exp_q[$];
  ev_t mon_obs[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  m_last = NR - 1;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_obs.delete();
      for (int i = 0; i < NR; i++) if (bus.req_byte_strobe[i]) mon_obs.push_back('{0, i, bus.incoming_byte});
      for (int i = 0; i < NR; i++) if (bus.req_done[i])        mon_obs.push_back('{1, i, 8'h00});
      for (int i = 0; i < NR; i++) if (bus.req_timeout[i])     mon_obs.push_back('{2, i, 8'h00});
      foreach (mon_obs[j]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got kind=%0d req=%0d data=%02h, expected no event",
                   mon_obs[j].kind, mon_obs[j].idx, mon_obs[j].data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== mon_obs[j].kind || mon_e.idx !== mon_obs[j].idx || mon_e.data !== mon_obs[j].data) begin
            errors++;
            $display("FAIL scoreboard_event: got kind=%0d req=%0d data=%02h, expected kind=%0d req=%0d data=%02h",
                     mon_obs[j].kind, mon_obs[j].idx, mon_obs[j].data, mon_e.kind, mon_e.idx, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_exec(output bit ok, output bit saw_idle, output int cyc);
    ok = 0; saw_idle = 0; cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.sd_execute) begin ok = 1; cyc = i; return; end
      if (bus.gnt == '0) saw_idle = 1;
    end
  endtask

  // Starts at the negedge of the ISSUE cycle; plays one full transfer for requester g.
  task automatic sd_serve(input int g, input int nbytes, input logic [7:0] base,
                          input logic [7:0] exp_out, input bit merge_last, input bit no_block);
    logic [NR-1:0] eg;
    bit bad;
    eg = '0; eg[g] = 1'b1; bad = 0;
    tick(); bus.sd_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sd_execute !== 1'b0) begin errors++; $display("FAIL exec_single_pulse: got %b expected 0", bus.sd_execute); end
    tick();
    for (int b = 0; b < nbytes; b++) begin
      bus.sd_incoming_byte = base + 8'(b);
      bus.sd_finished_byte = 1'b1;
      exp_q.push_back('{0, g, base + 8'(b)});
      if (merge_last && !no_block && b == nbytes - 1) begin
        bus.sd_finished_block = 1'b1;
        exp_q.push_back('{1, g, 8'h00});
      end
      @(negedge clk);
      if (bus.sd_outgoing_byte !== exp_out || bus.gnt !== eg) bad = 1;
      tick();
    end
    bus.sd_finished_byte = 1'b0;
    bus.sd_finished_block = 1'b0;
    if (no_block) begin
      bus.sd_busy = 1'b0; exp_q.push_back('{1, g, 8'h00}); tick();
    end else if (!merge_last) begin
      bus.sd_finished_block = 1'b1; exp_q.push_back('{1, g, 8'h00}); tick();
      bus.sd_finished_block = 1'b0;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL xfer_outgoing_gnt: got mismatching sd_outgoing_byte/gnt, expected %02h/%b", exp_out, eg); end
    @(negedge clk);
    checks++;
    if (bus.gnt !== eg || bus.sd_outgoing_byte !== 8'h00) begin
      errors++; $display("FAIL release_hold: got gnt=%b out=%02h expected gnt=%b out=00", bus.gnt, bus.sd_outgoing_byte, eg);
    end
    tick(); bus.sd_busy = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); end
    m_last = g;
  endtask

  task automatic test_reset();
    bus.sd_incoming_byte = 8'hFF;
    #2;
    checks++;
    if (bus.gnt !== '0 || bus.sd_execute !== 1'b0 || bus.sd_op_code !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got gnt=%b exe=%b op=%b expected 0", bus.gnt, bus.sd_execute, bus.sd_op_code);
    end
    checks++;
    if (bus.sd_block_address !== 32'h0 || bus.incoming_byte !== 8'h00 || bus.sd_outgoing_byte !== 8'h00) begin
      errors++; $display("FAIL reset_data: got addr=%h in=%h out=%h expected 0", bus.sd_block_address, bus.incoming_byte, bus.sd_outgoing_byte);
    end
    checks++;
    if (bus.req_byte_strobe !== '0 || bus.req_done !== '0 || bus.req_timeout !== '0) begin
      errors++; $display("FAIL reset_pulses: got %b/%b/%b expected 0", bus.req_byte_strobe, bus.req_done, bus.req_timeout);
    end
    bus.sd_incoming_byte = 8'h00;
    tick(); tick(); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.gnt !== '0) begin errors++; $display("FAIL idle_no_req: got gnt=%b expected 0", bus.gnt); end
  endtask

  task automatic test_init_busy();
    bit ok, si, bad; int cyc;
    bad = 0;
    bus.sd_busy = 1'b1;
    bus.req_block_address[0] = 32'h1234_5678;
    bus.req_op_code[0] = 1'b0;
    bus.req = 2'b01;
    repeat (100) begin @(negedge clk); if (bus.gnt !== '0) bad = 1; end
    checks++;
    if (bad) begin errors++; $display("FAIL init_no_grant: got a grant while busy, expected none"); end
    tick(); bus.sd_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0) begin errors++; $display("FAIL init_latency_early: got gnt=%b expected 00", bus.gnt); end
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || cyc != 0 || bus.gnt !== 2'b01) begin
      errors++; $display("FAIL init_grant: got ok=%0d cyc=%0d gnt=%b expected 1/0/01", ok, cyc, bus.gnt);
    end
    checks++;
    if (bus.sd_block_address !== 32'h1234_5678 || bus.sd_op_code !== 1'b0) begin
      errors++; $display("FAIL init_addr_op: got %h/%b expected 12345678/0", bus.sd_block_address, bus.sd_op_code);
    end
    bus.req = 2'b00;
    sd_serve(0, 8, 8'h30, 8'h00, 0, 0);
  endtask

  task automatic test_round_robin();
    bit ok, si; int cyc, eg;
    logic [NR-1:0] egv;
    bus.req = 2'b11;
    eg = (m_last + 1) % NR;
    for (int n = 0; n < 4; n++) begin
      wait_exec(ok, si, cyc);
      egv = '0; egv[eg] = 1'b1;
      checks++;
      if (!ok || bus.gnt !== egv) begin errors++; $display("FAIL rr_grant%0d: got gnt=%b expected %b", n, bus.gnt, egv); end
      checks++;
      if (!si) begin errors++; $display("FAIL rr_idle_gap%0d: got no idle cycle, expected at least 1", n); end
      if (n == 3) bus.req = 2'b00;
      sd_serve(eg, 4, 8'(8'h40 + 8'(n * 16)), 8'h00, 0, 0);
      eg = (eg + 1) % NR;
    end
  endtask

  task automatic test_read_stream();
    bit ok, si; int cyc;
    bus.req_block_address[1] = 32'h0000_0800;
    bus.req_op_code[1] = 1'b0;
    bus.req = 2'b10;
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || bus.gnt !== 2'b10 || bus.sd_block_address !== 32'h0000_0800 || bus.sd_op_code !== 1'b0) begin
      errors++; $display("FAIL read_grant: got gnt=%b addr=%h op=%b expected 10/00000800/0", bus.gnt, bus.sd_block_address, bus.sd_op_code);
    end
    bus.req = 2'b00;
    bus.req_block_address[1] = 32'hDEAD_BEEF;
    bus.req_op_code[1] = 1'b1;
    sd_serve(1, 512, 8'h00, 8'h00, 0, 0);
    checks++;
    if (bus.sd_block_address !== 32'h0000_0800 || bus.sd_op_code !== 1'b0) begin
      errors++; $display("FAIL read_latched: got %h/%b expected 00000800/0", bus.sd_block_address, bus.sd_op_code);
    end
    bus.req_op_code[1] = 1'b0;
  endtask

  task automatic test_write();
    bit ok, si; int cyc;
    bus.req_op_code[0] = 1'b1;
    bus.req_outgoing_byte[0] = 8'h5A;
    bus.req_outgoing_byte[1] = 8'hA5;
    bus.req_block_address[0] = 32'h0000_0042;
    @(negedge clk);
    checks++;
    if (bus.sd_outgoing_byte !== 8'h00) begin errors++; $display("FAIL write_out_idle: got %02h expected 00", bus.sd_outgoing_byte); end
    bus.req = 2'b01;
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || bus.gnt !== 2'b01 || bus.sd_op_code !== 1'b1 || bus.sd_outgoing_byte !== 8'h00) begin
      errors++; $display("FAIL write_issue: got gnt=%b op=%b out=%02h expected 01/1/00", bus.gnt, bus.sd_op_code, bus.sd_outgoing_byte);
    end
    bus.req = 2'b00;
    sd_serve(0, 8, 8'h10, 8'h5A, 1, 0);
    @(negedge clk);
    checks++;
    if (bus.sd_outgoing_byte !== 8'h00) begin errors++; $display("FAIL write_out_after: got %02h expected 00", bus.sd_outgoing_byte); end
    bus.req_op_code[0] = 1'b0;
  endtask

  task automatic test_busy_drop();
    bit ok, si; int cyc;
    bus.req = 2'b10;
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || bus.gnt !== 2'b10) begin errors++; $display("FAIL busydrop_grant: got gnt=%b expected 10", bus.gnt); end
    bus.req = 2'b00;
    sd_serve(1, 3, 8'h70, 8'hA5, 0, 1);
  endtask

  task automatic test_timeout();
    bit ok, si; int cyc, k;
    bus.req = 2'b11;
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || bus.gnt !== 2'b01) begin errors++; $display("FAIL tmo_grant: got gnt=%b expected 01", bus.gnt); end
    exp_q.push_back('{2, 0, 8'h00});
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.req_timeout !== '0) begin k = i; break; end
    end
    checks++;
    if (k != TMO) begin errors++; $display("FAIL tmo_cycle: got %0d expected %0d", k, TMO); end
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || !si || bus.gnt !== 2'b10) begin
      errors++; $display("FAIL tmo_next_grant: got ok=%0d idle=%0d gnt=%b expected 1/1/10", ok, si, bus.gnt);
    end
    bus.req = 2'b00;
    sd_serve(1, 4, 8'hC0, 8'hA5, 0, 0);
  endtask

  task automatic test_reset_mid_xfer();
    bit ok, si, bad; int cyc;
    bad = 0;
    bus.req = 2'b01;
    wait_exec(ok, si, cyc);
    tick(); bus.sd_busy = 1'b1;
    tick();
    bus.sd_incoming_byte = 8'h99; bus.sd_finished_byte = 1'b1;
    exp_q.push_back('{0, 0, 8'h99});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.req_byte_strobe !== '0 || bus.sd_execute !== 1'b0 || bus.incoming_byte !== 8'h00 ||
        bus.sd_outgoing_byte !== 8'h00 || bus.sd_block_address !== 32'h0 || bus.sd_op_code !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got gnt=%b strb=%b in=%02h addr=%h expected all 0",
                         bus.gnt, bus.req_byte_strobe, bus.incoming_byte, bus.sd_block_address);
    end
    bus.sd_finished_byte = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    bus.req = 2'b11;
    repeat (10) begin @(negedge clk); if (bus.gnt !== '0) bad = 1; end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_wait_busy: got a grant while busy, expected none"); end
    tick(); bus.sd_busy = 1'b0;
    wait_exec(ok, si, cyc);
    checks++;
    if (!ok || bus.gnt !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got gnt=%b expected 01", bus.gnt); end
    bus.req = 2'b00;
    sd_serve(0, 4, 8'hE0, 8'h5A, 0, 0);
  endtask

  initial begin
    bus.req = '0; bus.req_op_code = '0; bus.req_block_address = '0; bus.req_outgoing_byte = '0;
    bus.sd_incoming_byte = 8'h00; bus.sd_finished_byte = 1'b0; bus.sd_finished_block = 1'b0; bus.sd_busy = 1'b0;
    test_reset();
    test_init_busy();
    test_round_robin();
    test_read_stream();
    test_write();
    test_busy_drop();
    test_timeout();
    test_reset_mid_xfer();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
